// File: rtl/mono2_rx_pkg.sv
// Shared types and helpers for the LF-Monopix2 token readout sequencer.
package mono2_rx_pkg;

   localparam int DATA_BITS_DEF = 27;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      CHECK,
      READ,
      DLY,
      SHIFT,
      PUSH,
      STOP
   } rx_state_t;

   function automatic int hit_cnt_w(input int max_hits);
      return $clog2(max_hits + 1);
   endfunction

endpackage

// File: rtl/mono2_sync2.sv
// Two-flop synchroniser for a single asynchronous level into the CLK40 domain.
module mono2_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_ff;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ff <= 2'b00;
      end else begin
         r_ff <= {r_ff[0], i_d};
      end
   end

   assign o_q = r_ff[1];

endmodule

// File: rtl/mono2_token_readout.sv
// Token-driven Freeze/Read sequencer and hit-word deserialiser for LF-Monopix2.
module mono2_token_readout
   import mono2_rx_pkg::*;
#(
   parameter int DATA_BITS    = DATA_BITS_DEF,
   parameter int READ_CYC     = 2,
   parameter int FREEZE_SETUP = 4,
   parameter int TOK_GUARD    = 3,
   parameter int MAX_HITS     = 1024
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CONF_EN,
   input  logic [7:0]           CONF_READ_DLY,
   input  logic [7:0]           CONF_FREEZE_STOP,
   input  logic                 CONF_CLR_ERR,
   input  logic                 RX_TOKEN,
   input  logic                 RX_DATA,
   output logic                 RX_FREEZE,
   output logic                 RX_READ,
   output logic [DATA_BITS-1:0] OUT_DATA,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic                 BUSY,
   output logic [15:0]          FRAME_CNT,
   output logic                 ERR_OVF
);

   localparam int            HW      = hit_cnt_w(MAX_HITS);
   localparam logic [HW-1:0] HIT_MAX = HW'(MAX_HITS);
   localparam logic [HW-1:0] HIT_ONE = HW'(1);

   rx_state_t            r_state;
   logic [15:0]          r_cnt;
   logic [DATA_BITS-2:0] r_shreg;
   logic [HW-1:0]        r_hit;
   logic                 r_freeze;
   logic                 r_read;
   logic                 r_valid;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_busy;
   logic [15:0]          r_frame;
   logic                 r_err;

   logic                 w_tok_s;
   rx_state_t            w_state_n;
   logic [15:0]          w_cnt_n;
   logic [15:0]          w_cnt_dec;
   logic [15:0]          w_stop_ld;
   logic [15:0]          w_dly_ld;
   logic [DATA_BITS-2:0] w_shreg_n;
   logic [DATA_BITS-1:0] w_sample;
   logic [HW-1:0]        w_hit_n;
   logic                 w_freeze_n;
   logic                 w_read_n;
   logic                 w_valid_n;
   logic [DATA_BITS-1:0] w_data_n;
   logic [15:0]          w_frame_n;
   logic                 w_err_set;

   mono2_sync2 u_tok_sync (
      .i_clk (CLK),
      .i_rst (RST),
      .i_d   (RX_TOKEN),
      .o_q   (w_tok_s)
   );

   assign w_cnt_dec = r_cnt - 16'd1;
   assign w_sample  = {r_shreg, RX_DATA};
   assign w_dly_ld  = {8'd0, CONF_READ_DLY} - 16'd1;
   // A zero stop time still costs one STOP cycle before Freeze drops.
   assign w_stop_ld = (CONF_FREEZE_STOP == 8'd0) ? 16'd0
                    : {8'd0, CONF_FREEZE_STOP} - 16'd1;

   always_comb begin
      w_state_n  = r_state;
      w_cnt_n    = r_cnt;
      w_shreg_n  = r_shreg;
      w_hit_n    = r_hit;
      w_freeze_n = r_freeze;
      w_read_n   = r_read;
      w_valid_n  = r_valid;
      w_data_n   = r_data;
      w_frame_n  = r_frame;
      w_err_set  = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_freeze_n = 1'b0;
            if (CONF_EN && w_tok_s) begin
               w_state_n  = SETUP;
               w_cnt_n    = 16'(FREEZE_SETUP - 1);
               w_freeze_n = 1'b1;
            end
         end
         SETUP: begin
            if (r_cnt == 16'd0) begin
               w_state_n = CHECK;
            end else begin
               w_cnt_n = w_cnt_dec;
            end
         end
         CHECK: begin
            if (!w_tok_s) begin
               w_state_n = STOP;
               w_cnt_n   = w_stop_ld;
            end else if (r_hit >= HIT_MAX) begin
               w_err_set = 1'b1;
               w_state_n = STOP;
               w_cnt_n   = w_stop_ld;
            end else begin
               w_state_n = READ;
               w_cnt_n   = 16'(READ_CYC - 1);
               w_read_n  = 1'b1;
            end
         end
         READ: begin
            if (r_cnt == 16'd0) begin
               w_read_n = 1'b0;
               if (CONF_READ_DLY == 8'd0) begin
                  w_state_n = SHIFT;
                  w_cnt_n   = 16'(DATA_BITS - 1);
               end else begin
                  w_state_n = DLY;
                  w_cnt_n   = w_dly_ld;
               end
            end else begin
               w_cnt_n = w_cnt_dec;
            end
         end
         DLY: begin
            if (r_cnt == 16'd0) begin
               w_state_n = SHIFT;
               w_cnt_n   = 16'(DATA_BITS - 1);
            end else begin
               w_cnt_n = w_cnt_dec;
            end
         end
         SHIFT: begin
            w_shreg_n = w_sample[DATA_BITS-2:0];
            if (r_cnt == 16'd0) begin
               w_state_n = PUSH;
               w_data_n  = w_sample;
               w_valid_n = 1'b1;
            end else begin
               w_cnt_n = w_cnt_dec;
            end
         end
         PUSH: begin
            // Valid low inside PUSH means the token-guard wait is running.
            if (r_valid) begin
               if (OUT_READY) begin
                  w_valid_n = 1'b0;
                  w_cnt_n   = 16'(TOK_GUARD - 1);
                  if (r_hit < HIT_MAX) begin
                     w_hit_n = r_hit + HIT_ONE;
                  end
               end
            end else if (r_cnt == 16'd0) begin
               w_state_n = CHECK;
            end else begin
               w_cnt_n = w_cnt_dec;
            end
         end
         STOP: begin
            if (r_cnt == 16'd0) begin
               w_state_n  = IDLE;
               w_freeze_n = 1'b0;
               w_frame_n  = r_frame + 16'd1;
               w_hit_n    = '0;
            end else begin
               w_cnt_n = w_cnt_dec;
            end
         end
         default: begin
            w_state_n  = IDLE;
            w_freeze_n = 1'b0;
            w_read_n   = 1'b0;
            w_valid_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= IDLE;
         r_cnt    <= 16'd0;
         r_shreg  <= '0;
         r_hit    <= '0;
         r_freeze <= 1'b0;
         r_read   <= 1'b0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_busy   <= 1'b0;
         r_frame  <= 16'd0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_shreg  <= w_shreg_n;
         r_hit    <= w_hit_n;
         r_freeze <= w_freeze_n;
         r_read   <= w_read_n;
         r_valid  <= w_valid_n;
         r_data   <= w_data_n;
         r_busy   <= (w_state_n != IDLE);
         r_frame  <= w_frame_n;
         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (CONF_CLR_ERR) begin
            r_err <= 1'b0;
         end
      end
   end

   assign RX_FREEZE = r_freeze;
   assign RX_READ   = r_read;
   assign OUT_DATA  = r_data;
   assign OUT_VALID = r_valid;
   assign BUSY      = r_busy;
   assign FRAME_CNT = r_frame;
   assign ERR_OVF   = r_err;

endmodule

// File: tb/tb_mono2_token_readout.sv
// Randomised bench for mono2_token_readout with a behavioural chip and scoreboard.
module tb_mono2_token_readout;

   localparam int DB   = 27;
   localparam int RC   = 2;
   localparam int MAXH = 4;

   logic          CLK;
   logic          RST;
   logic          CONF_EN;
   logic [7:0]    CONF_READ_DLY;
   logic [7:0]    CONF_FREEZE_STOP;
   logic          CONF_CLR_ERR;
   logic          RX_TOKEN;
   logic          RX_DATA;
   logic          RX_FREEZE;
   logic          RX_READ;
   logic [DB-1:0] OUT_DATA;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic          BUSY;
   logic [15:0]   FRAME_CNT;
   logic          ERR_OVF;

   int            n_chk = 0;
   int            n_err = 0;
   logic [DB-1:0] chip_q[$];
   logic [DB-1:0] sb_q[$];
   bit            chip_abort = 0;
   int            rdy_mode = 0;
   int            rd_n = 0;
   int            rd_w = 0;
   int            fz_n = 0;
   int            n_loaded = 0;
   int            frame_rd0 = 0;
   int            exp_frames = 0;
   logic [DB-1:0] last_word = '0;
   logic [DB-1:0] hold_data = '0;
   bit            hold = 0;

   mono2_token_readout #(.MAX_HITS(MAXH)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .CONF_EN          (CONF_EN),
      .CONF_READ_DLY    (CONF_READ_DLY),
      .CONF_FREEZE_STOP (CONF_FREEZE_STOP),
      .CONF_CLR_ERR     (CONF_CLR_ERR),
      .RX_TOKEN         (RX_TOKEN),
      .RX_DATA          (RX_DATA),
      .RX_FREEZE        (RX_FREEZE),
      .RX_READ          (RX_READ),
      .OUT_DATA         (OUT_DATA),
      .OUT_VALID        (OUT_VALID),
      .OUT_READY        (OUT_READY),
      .BUSY             (BUSY),
      .FRAME_CNT        (FRAME_CNT),
      .ERR_OVF          (ERR_OVF)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Chip: token high while hits remain; each Read fall ships one word MSB first.
   initial begin : chip
      bit            pr;
      int            d;
      logic [DB-1:0] w;
      pr = 0;
      RX_DATA = 1'b0;
      RX_TOKEN = 1'b0;
      forever begin
         @(posedge CLK); #1;
         RX_TOKEN = (chip_q.size() != 0);
         if (pr && !RX_READ && chip_q.size() != 0) begin
            w = chip_q.pop_front();
            RX_TOKEN = (chip_q.size() != 0);
            d = int'(CONF_READ_DLY);
            repeat (d) begin
               @(posedge CLK); #1;
               RX_TOKEN = (chip_q.size() != 0);
            end
            for (int k = 0; k < DB; k++) begin
               if (chip_abort) break;
               RX_DATA = w[DB-1-k];
               @(posedge CLK); #1;
               RX_TOKEN = (chip_q.size() != 0);
            end
         end
         pr = RX_READ;
      end
   end

   initial begin : ready_drv
      OUT_READY = 1'b0;
      forever begin
         @(posedge CLK); #1;
         case (rdy_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = ($urandom_range(0, 3) != 0);
            default: OUT_READY = 1'b0;
         endcase
      end
   end

   always @(negedge CLK) begin
      chk("frz_eq_busy", RX_FREEZE, BUSY);
      if (RX_READ) begin
         rd_w++;
      end else if (rd_w != 0) begin
         chk("read_width", rd_w, RC);
         rd_n++;
         rd_w = 0;
      end
      if (ERR_OVF && RX_FREEZE) fz_n++;
      if (!RST && hold) begin
         chk("hold_valid", OUT_VALID, 1);
         chk("hold_data", OUT_DATA, hold_data);
      end
      if (OUT_VALID) begin
         chk("push_noread", RX_READ, 0);
         chk("push_freeze", RX_FREEZE, 1);
      end
      if (OUT_VALID && OUT_READY) begin
         if (sb_q.size() == 0) chk("sb_extra", sb_q.size(), 1);
         else chk("word", OUT_DATA, sb_q.pop_front());
         last_word = OUT_DATA;
      end
      hold = OUT_VALID && !OUT_READY;
      hold_data = OUT_DATA;
   end

   task automatic push_hit(input logic [DB-1:0] w);
      if (n_loaded == 0) frame_rd0 = rd_n;
      chip_q.push_back(w);
      if (n_loaded < MAXH) sb_q.push_back(w);
      n_loaded++;
   endtask

   task automatic run_frame(input bit drop_en);
      int t;
      int exp_rd;
      exp_rd = (n_loaded < MAXH) ? n_loaded : MAXH;
      t = 0;
      while (!BUSY && t < 50) begin @(negedge CLK); t++; end
      chk("start", BUSY, 1);
      if (drop_en) CONF_EN = 1'b0;
      t = 0;
      while (BUSY && t < 5000) begin @(negedge CLK); t++; end
      chk("done", BUSY, 0);
      exp_frames++;
      chk("frame_cnt", FRAME_CNT, 16'(exp_frames));
      chk("reads", rd_n - frame_rd0, exp_rd);
      chk("sb_empty", sb_q.size(), 0);
      chk("err_ovf", ERR_OVF, n_loaded > MAXH);
      n_loaded = 0;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int            t;
      int            r0;
      int            f0;
      int            cnt;
      logic [DB-1:0] w;
      logic [DB-1:0] w0;
      RST = 1'b1;
      CONF_EN = 1'b0;
      CONF_CLR_ERR = 1'b0;
      CONF_READ_DLY = 8'd0;
      CONF_FREEZE_STOP = 8'd2;
      repeat (3) @(negedge CLK);
      chk("rst_outs", {RX_FREEZE, RX_READ, OUT_VALID, BUSY, ERR_OVF,
                       FRAME_CNT, OUT_DATA}, 0);
      RST = 1'b0;
      CONF_EN = 1'b1;
      repeat (3) @(negedge CLK);

      push_hit(27'h5A5A5A5);
      run_frame(0);

      CONF_READ_DLY = 8'd1;
      push_hit(27'd1); push_hit(27'd2); push_hit(27'd3);
      run_frame(0);

      rdy_mode = 2;
      push_hit(27'($urandom));
      t = 0;
      while (!OUT_VALID && t < 200) begin @(negedge CLK); t++; end
      chk("stall_seen", OUT_VALID, 1);
      r0 = rd_n;
      repeat (20) @(negedge CLK);
      chk("stall_valid", OUT_VALID, 1);
      chk("stall_reads", rd_n - r0, 0);
      chk("stall_freeze", RX_FREEZE, 1);
      rdy_mode = 0;
      run_frame(0);

      rdy_mode = 1;
      for (int i = 0; i < 8; i++) begin
         CONF_READ_DLY = 8'($urandom_range(0, 5));
         CONF_FREEZE_STOP = 8'($urandom_range(0, 6));
         for (int j = 0; j < int'($urandom_range(1, 3)); j++)
            push_hit(27'($urandom));
         run_frame(0);
      end
      rdy_mode = 0;

      w = 27'($urandom);
      CONF_READ_DLY = 8'd0;
      push_hit(w);
      run_frame(0);
      w0 = last_word;
      CONF_READ_DLY = 8'd3;
      push_hit(w);
      run_frame(0);
      chk("dly_same_word", last_word, w0);

      CONF_FREEZE_STOP = 8'd5;
      f0 = fz_n;
      for (int i = 0; i < 6; i++) push_hit(27'($urandom));
      run_frame(1);
      chk("freeze_stop", fz_n - f0, 5);
      repeat (5) @(negedge CLK);
      chk("err_sticky", ERR_OVF, 1);
      chip_q.delete();
      repeat (6) @(negedge CLK);
      CONF_EN = 1'b1;
      CONF_CLR_ERR = 1'b1;
      @(negedge CLK);
      CONF_CLR_ERR = 1'b0;
      chk("err_clear", ERR_OVF, 0);
      chk("idle_after_clr", BUSY, 0);

      CONF_READ_DLY = 8'd0;
      push_hit(27'($urandom));
      push_hit(27'($urandom));
      r0 = rd_n;
      t = 0;
      while (rd_n == r0 && t < 300) begin @(negedge CLK); t++; end
      chk("t5_read", rd_n - r0, 1);
      repeat (5) @(posedge CLK);
      #3;
      chk("pre_rst_busy", BUSY, 1);
      RST = 1'b1;
      #1;
      chk("rst_mid", {RX_FREEZE, RX_READ, OUT_VALID, BUSY, ERR_OVF,
                      FRAME_CNT, OUT_DATA}, 0);
      chip_abort = 1;
      CONF_EN = 1'b0;
      sb_q.delete();
      exp_frames = 0;
      n_loaded = 0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("rel_busy", BUSY, 0);
      cnt = 0;
      repeat (20) begin
         @(negedge CLK);
         if (RX_FREEZE || BUSY) cnt++;
      end
      chk("no_en_freeze", cnt, 0);
      chip_q.delete();
      repeat (6) @(negedge CLK);
      chip_abort = 0;
      CONF_EN = 1'b1;
      push_hit(27'($urandom));
      run_frame(0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
